spi_frame_receiver: RTL
=======================

Name: spi_frame_receiver

Overview:
- SPI mode-0 minion front end. Sits directly upstream of the SPI memory-write client.
- Synchronises the external cs, sclk and mosi pins into the clk domain and deserialises one nbits-wide word per chip-select frame, presenting it as a one-cycle push.
- In the same frame it serialises a pull word onto miso.
- Replaces ad-hoc minion logic; the memory client consumes push_msg/push_en directly.

Parameters:
- nbits, 32, bits per SPI frame (push and pull word width); legal range 2..64.
- sync_stages, 2, synchroniser flops per input pin; legal range 2..3.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cs  in  1  chip select, active-low, asynchronous to clk
- sclk  in  1  SPI clock, asynchronous to clk, idles low
- mosi  in  1  serial data in, MSB first
- miso  out  1  serial data out, MSB first
- push_msg  out  nbits  last complete received word
- push_en  out  1  one-cycle strobe: push_msg valid
- pull_msg  in  nbits  word to transmit; sampled when pull_en=1
- pull_en  out  1  one-cycle strobe at frame start; pull_msg captured this cycle
- parity  out  1  XOR-reduction of push_msg, updated with push_en
- frame_err  out  1  one-cycle strobe: frame ended with bit count != nbits

Behaviour:
- Reset values: miso=0, push_msg=0, push_en=0, pull_en=0, parity=0, frame_err=0. Synchroniser and edge-history flops reset to idle levels (cs=1, sclk=0, mosi=0).
- Synchronisation: each pin passes through sync_stages flops, then one history flop. Edges are detected from (synced, history). With sync_stages=2, a pin change sampled at clk edge N is acted on at edge N+2, and the resulting registered strobe is visible after edge N+3.
- Timing requirement: each sclk high and low phase lasts ≥ sync_stages+2 clk periods. Behaviour is undefined otherwise.
- FSM states:
  - IDLE: cs high. On cs fall → ACTIVE. Pulse pull_en; load tx shift reg from pull_msg; clear bit counter and rx shift reg; drive miso = pull_msg[nbits-1].
  - ACTIVE: on sclk rise → shift mosi into rx reg LSB (shift left); bit counter +1, saturating at nbits+1.
  - ACTIVE: on sclk fall → shift tx reg left; miso = new MSB. After nbits falls, miso=0.
  - ACTIVE: on cs rise → DONE.
  - DONE (one cycle):
    - If count == nbits: push_en=1, push_msg=rx reg, parity=^rx reg.
    - Else: frame_err=1; push_msg and parity hold.
    - Then → IDLE.
  - RESYNC: entered from reset if synced cs=0. No strobes; ignores sclk; → IDLE when synced cs=1. Reset never produces a partial push.
- Reset state selection: after rst deasserts, the FSM is in IDLE if synced cs is high, else RESYNC. Evaluated in the first non-reset cycle.
- Bit count: rx reg holds the first nbits bits only. Bits beyond nbits are ignored for data but counted; count saturates at nbits+1, which yields frame_err.
- Simultaneous sclk edge and cs rise in the same cycle: the cs rise wins and the sclk edge is dropped.
- cs fall while in DONE: cannot occur (cs must stay high ≥ sync_stages+2 clk); behaviour undefined.
- A zero-length frame (cs low then high, no sclk) gives frame_err=1.
- Strobes are exactly one cycle. There is no backpressure; the downstream block must accept push_en on every assertion.
- miso is registered and changes only in the cycle after a detected sclk fall or cs fall.
- rst asserted mid-frame: all outputs return to reset values on the next edge; the frame is discarded.

Test Plan:
- Single frame, nbits=32: cs low, shift 0xDEADBEEF MSB-first, cs high → push_en one cycle, push_msg=0xDEADBEEF, parity=0 (24 ones), frame_err=0, latency cs-rise-sampled→push_en = 3 clk.
- Pull path: pull_msg=0xA5A5_0001 at the pull_en cycle → miso bits captured on sclk rises read 0xA5A50001; after the 32nd fall, miso=0.
- Short and long frames: 31 bits then cs high → frame_err one cycle, push_en=0, push_msg unchanged; 33 bits → frame_err=1; zero-bit frame → frame_err=1.
- Back-to-back: addr 0x00000100 then data 0x12345678 in two frames separated by minimum cs-high time → two push_en strobes in order with those values; parity=1, then 1 (13 ones).
- Reset mid-frame: rst asserted after 16 bits with cs held low, released → RESYNC, no push/frame_err until cs high; the next full frame 0x0000_0001 → push_en, push_msg=1, parity=1.
- Coincident cs rise and sclk rise in the same synced cycle after 32 bits → push_en with the correct 32-bit word; the extra edge is not counted.

Source files
------------

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 minion front end: synchronises cs/sclk/mosi into clk, deserialises one
// nbits word per chip-select frame into a push strobe and shifts a pull word onto miso.
module spi_frame_receiver #(
  parameter int unsigned nbits       = 32,
  parameter int unsigned sync_stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic [nbits-1:0] push_msg,
  output logic             push_en,
  input  logic [nbits-1:0] pull_msg,
  output logic             pull_en,
  output logic             parity,
  output logic             frame_err
);
  localparam int unsigned   CW       = $clog2(nbits + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(nbits);
  localparam logic [CW-1:0] CNT_SAT  = CW'(nbits + 1);
  localparam logic [1:0]    FLUSH    = 2'(sync_stages);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, RESYNC} state_e;

  logic [sync_stages-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_hist_q, sclk_hist_q;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_rise, cs_fall, sclk_rise, sclk_fall;

  state_e                 state_q;
  logic [1:0]             flush_q;
  logic [CW-1:0]          cnt_q;
  logic [nbits-1:0]       rx_q, tx_q, push_msg_q;
  logic                   miso_q, push_en_q, pull_en_q, parity_q, frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_hist_q   <= 1'b1;
      sclk_hist_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[sync_stages-2:0], cs};
      sclk_sync_q <= {sclk_sync_q[sync_stages-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[sync_stages-2:0], mosi};
      cs_hist_q   <= cs_s;
      sclk_hist_q <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_q[sync_stages-1];
  assign sclk_s    = sclk_sync_q[sync_stages-1];
  assign mosi_s    = mosi_sync_q[sync_stages-1];
  assign cs_fall   = cs_hist_q & ~cs_s;
  assign cs_rise   = ~cs_hist_q & cs_s;
  assign sclk_rise = ~sclk_hist_q & sclk_s;
  assign sclk_fall = sclk_hist_q & ~sclk_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESYNC;
      flush_q     <= FLUSH;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      push_msg_q  <= '0;
      miso_q      <= 1'b0;
      push_en_q   <= 1'b0;
      pull_en_q   <= 1'b0;
      parity_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_en_q   <= 1'b0;
      pull_en_q   <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        // The synchroniser still shows idle levels right after reset, so the cs
        // decision waits until the real pin level has flushed through it.
        RESYNC: begin
          if (flush_q != 2'd0) flush_q <= flush_q - 2'd1;
          else if (cs_s)       state_q <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state_q   <= ACTIVE;
            pull_en_q <= 1'b1;
            cnt_q     <= '0;
            rx_q      <= '0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q <= DONE;
          end else if (pull_en_q) begin
            // tx_q holds the bits still to follow the one already on miso.
            miso_q <= pull_msg[nbits-1];
            tx_q   <= {pull_msg[nbits-2:0], 1'b0};
          end else begin
            if (sclk_rise) begin
              if (cnt_q < CNT_FULL) rx_q <= {rx_q[nbits-2:0], mosi_s};
              if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
            end
            if (sclk_fall) begin
              miso_q <= tx_q[nbits-1];
              tx_q   <= {tx_q[nbits-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (cnt_q == CNT_FULL) begin
            push_en_q  <= 1'b1;
            push_msg_q <= rx_q;
            parity_q   <= ^rx_q;
          end else begin
            frame_err_q <= 1'b1;
          end
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign miso      = miso_q;
  assign push_msg  = push_msg_q;
  assign push_en   = push_en_q;
  assign pull_en   = pull_en_q;
  assign parity    = parity_q;
  assign frame_err = frame_err_q;

endmodule
